// File: rtl/fpio_fifo_in_client_mux.sv
// rtl/fpio_fifo_in_client_mux.sv - per-channel FIFOs arbitrated onto one fpio FIFO write port
// Each channel buffers privately; one word per cycle is forwarded, tagged with its channel.
module fpio_fifo_in_client_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int ARB_MODE     = 0,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS-1:0]            ch_wr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CHANNELS-1:0]            ch_full,
  output logic [NUM_CHANNELS*CW-1:0]         ch_count,
  output logic [NUM_CHANNELS-1:0]            ch_ovf,
  input  logic [NUM_CHANNELS-1:0]            ch_ovf_clr,
  output logic                               fifo_wr,
  output logic [DATA_WIDTH-1:0]              fifo_wdata,
  output logic [IW-1:0]                      fifo_ch,
  input  logic                               fifo_full
);
  localparam int PW = CW - 1;

  logic [NUM_CHANNELS-1:0]            req;
  logic [NUM_CHANNELS-1:0]            pop;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] head;
  logic [IW-1:0]                      last_grant_q, last_grant_d;
  logic [IW-1:0]                      grant_idx;
  logic                               grant_found;

  // Round-robin search begins just after the last granted channel.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (ARB_MODE == 1) begin
        if (!grant_found && req[k]) begin
          grant_idx   = IW'(k);
          grant_found = 1'b1;
        end
      end else begin
        if (!grant_found && req[(int'(last_grant_q) + 1 + k) % NUM_CHANNELS]) begin
          grant_idx   = IW'((int'(last_grant_q) + 1 + k) % NUM_CHANNELS);
          grant_found = 1'b1;
        end
      end
    end
  end

  assign fifo_wr    = (|req) & ~fifo_full;
  assign fifo_ch    = grant_idx;
  assign fifo_wdata = head[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    last_grant_d = last_grant_q;
    if (ARB_MODE == 0 && fifo_wr) begin
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IW'(NUM_CHANNELS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  full;
    logic                  push;

    // Full is judged on the pre-pop count, so a push into a full FIFO is dropped even if it pops.
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign push   = ch_wr[i] & ~full;
    assign pop[i] = fifo_wr & (grant_idx == IW'(i));
    assign req[i] = (count_q != '0);

    always_comb begin
      wr_ptr_d = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop[i] ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop[i]);
      ovf_d    = (ch_wr[i] & full) | (ovf_q & ~ch_ovf_clr[i]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && push) begin
        mem_q[wr_ptr_q] <= ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign head[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];
    assign ch_full[i]                       = full;
    assign ch_count[i*CW +: CW]             = count_q;
    assign ch_ovf[i]                        = ovf_q;
  end

endmodule

// File: tb/tb_fpio_fifo_in_client_mux.sv
// tb/tb_fpio_fifo_in_client_mux.sv - scoreboard bench for round-robin and fixed-priority instances
// Both instances see identical stimulus; each has its own expected-word queue.
module tb_fpio_fifo_in_client_mux;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int DW = 8;
  localparam int CW = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_wr;
  logic [N*DW-1:0] ch_wdata;
  logic [N-1:0]  ch_ovf_clr;
  logic          fifo_full;

  logic [N-1:0]    ch_full_rr, ch_ovf_rr, ch_full_fp, ch_ovf_fp;
  logic [N*CW-1:0] ch_count_rr, ch_count_fp;
  logic            fifo_wr_rr, fifo_wr_fp;
  logic [DW-1:0]   fifo_wdata_rr, fifo_wdata_fp;
  logic [IW-1:0]   fifo_ch_rr, fifo_ch_fp;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_rr[$];
  logic [11:0] exp_fp[$];
  logic [11:0] e_rr, e_fp;

  fpio_fifo_in_client_mux #(.NUM_CHANNELS(N), .FIFO_DEPTH(D), .DATA_WIDTH(DW), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .ch_wr(ch_wr), .ch_wdata(ch_wdata), .ch_full(ch_full_rr),
    .ch_count(ch_count_rr), .ch_ovf(ch_ovf_rr), .ch_ovf_clr(ch_ovf_clr), .fifo_wr(fifo_wr_rr),
    .fifo_wdata(fifo_wdata_rr), .fifo_ch(fifo_ch_rr), .fifo_full(fifo_full)
  );

  fpio_fifo_in_client_mux #(.NUM_CHANNELS(N), .FIFO_DEPTH(D), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .ch_wr(ch_wr), .ch_wdata(ch_wdata), .ch_full(ch_full_fp),
    .ch_count(ch_count_fp), .ch_ovf(ch_ovf_fp), .ch_ovf_clr(ch_ovf_clr), .fifo_wr(fifo_wr_fp),
    .fifo_wdata(fifo_wdata_fp), .fifo_ch(fifo_ch_fp), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_both(input int ch, input logic [7:0] d);
    exp_rr.push_back({4'(ch), d});
    exp_fp.push_back({4'(ch), d});
  endtask

  always @(negedge clk) begin
    if (!rst && fifo_wr_rr) begin
      if (exp_rr.size() == 0) begin
        chk("rr_extra_word", 32'(fifo_wr_rr), 32'd0);
      end else begin
        e_rr = exp_rr.pop_front();
        chk("rr_ch", 32'(fifo_ch_rr), 32'(e_rr[11:8]));
        chk("rr_data", 32'(fifo_wdata_rr), 32'(e_rr[7:0]));
      end
    end
    if (!rst && fifo_wr_fp) begin
      if (exp_fp.size() == 0) begin
        chk("fp_extra_word", 32'(fifo_wr_fp), 32'd0);
      end else begin
        e_fp = exp_fp.pop_front();
        chk("fp_ch", 32'(fifo_ch_fp), 32'(e_fp[11:8]));
        chk("fp_data", 32'(fifo_wdata_fp), 32'(e_fp[7:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n;
    int sent;
    rst        = 1'b1;
    ch_wr      = '0;
    ch_wdata   = '0;
    ch_ovf_clr = '0;
    fifo_full  = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", 32'(ch_count_rr), 32'd0);
    chk("reset_full", 32'(ch_full_rr), 32'd0);
    chk("reset_ovf", 32'(ch_ovf_rr), 32'd0);
    chk("reset_fifo_wr", 32'(fifo_wr_rr), 32'd0);
    step();

    // Preload 4 words on every channel while downstream is full.
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < N; c++) begin
        ch_wdata[c*DW +: DW] = 8'(c*16 + w);
        exp_rr.push_back({4'(c), 8'(c*16 + w)});
      end
      ch_wr = '1;
      step();
    end
    for (int c = 0; c < N; c++) begin
      for (int w = 0; w < 4; w++) exp_fp.push_back({4'(c), 8'(c*16 + w)});
    end
    ch_wr = '0;
    chk("preload_count", 32'(ch_count_rr), 32'({4{5'd4}}));
    chk("preload_no_wr", 32'(fifo_wr_rr), 32'd0);
    fifo_full = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_stream_wr", 32'(fifo_wr_rr), 32'd1);
      chk("fp_stream_wr", 32'(fifo_wr_fp), 32'd1);
      step();
    end
    @(negedge clk);
    chk("stream_done_wr", 32'(fifo_wr_rr), 32'd0);
    chk("rr_sb_empty", 32'(exp_rr.size()), 32'd0);
    chk("fp_sb_empty", 32'(exp_fp.size()), 32'd0);
    step();

    // Reset in the middle of buffered traffic, with writes and clears held during reset.
    fifo_full = 1'b1;
    ch_wr = 4'b0101;
    ch_wdata = {4{8'h11}};
    step();
    step();
    rst = 1'b1;
    ch_wr = '1;
    ch_ovf_clr = '1;
    exp_rr.delete();
    exp_fp.delete();
    step();
    step();
    rst = 1'b0;
    ch_wr = '0;
    ch_ovf_clr = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(ch_count_rr), 32'd0);
    chk("midrst_full", 32'(ch_full_rr), 32'd0);
    chk("midrst_ovf", 32'(ch_ovf_rr), 32'd0);
    chk("midrst_fifo_wr", 32'(fifo_wr_rr), 32'd0);
    repeat (3) begin
      step();
      @(negedge clk);
      chk("midrst_no_stale", 32'(fifo_wr_rr), 32'd0);
    end
    step();

    // Single-word latency on channel 2.
    ch_wr = 4'b0100;
    ch_wdata[2*DW +: DW] = 8'hA5;
    expect_both(2, 8'hA5);
    step();
    ch_wr = '0;
    @(negedge clk);
    chk("lat_fifo_wr", 32'(fifo_wr_rr), 32'd1);
    chk("lat_data", 32'(fifo_wdata_rr), 32'hA5);
    chk("lat_ch", 32'(fifo_ch_rr), 32'd2);
    step();

    // Overflow channel 1 with 17 words while downstream is blocked.
    fifo_full = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      ch_wr = 4'b0010;
      ch_wdata[1*DW +: DW] = 8'(k);
      if (k <= 16) expect_both(1, 8'(k));
      step();
      if (k == 15) chk("ovf_full_at15", 32'(ch_full_rr[1]), 32'd0);
      if (k == 16) begin
        chk("ovf_full_at16", 32'(ch_full_rr[1]), 32'd1);
        chk("ovf_flag_at16", 32'(ch_ovf_rr[1]), 32'd0);
        chk("ovf_count_at16", 32'(ch_count_rr[1*CW +: CW]), 32'd16);
      end
      if (k == 17) begin
        chk("ovf_flag_at17", 32'(ch_ovf_rr[1]), 32'd1);
        chk("ovf_count_at17", 32'(ch_count_rr[1*CW +: CW]), 32'd16);
      end
    end
    ch_wr = '0;
    fifo_full = 1'b0;
    n = 0;
    while (exp_rr.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("ovf_drain_empty", 32'(exp_rr.size()), 32'd0);
    chk("ovf_drain_count", 32'(ch_count_rr[1*CW +: CW]), 32'd0);
    chk("ovf_sticky", 32'(ch_ovf_rr[1]), 32'd1);
    ch_ovf_clr = 4'b0010;
    step();
    ch_ovf_clr = '0;
    chk("ovf_cleared", 32'(ch_ovf_rr[1]), 32'd0);

    // Refill, then write+clear while full and popping: pop happens, push drops, set wins.
    fifo_full = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      ch_wr = 4'b0010;
      ch_wdata[1*DW +: DW] = 8'(100 + k);
      expect_both(1, 8'(100 + k));
      step();
    end
    chk("refill_full", 32'(ch_full_rr[1]), 32'd1);
    ch_wr = 4'b0010;
    ch_wdata[1*DW +: DW] = 8'hEE;
    ch_ovf_clr = 4'b0010;
    fifo_full = 1'b0;
    step();
    ch_wr = '0;
    ch_ovf_clr = '0;
    chk("setclr_ovf", 32'(ch_ovf_rr[1]), 32'd1);
    chk("setclr_count", 32'(ch_count_rr[1*CW +: CW]), 32'd15);
    chk("setclr_full", 32'(ch_full_rr[1]), 32'd0);
    n = 0;
    while (exp_rr.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("setclr_drain_empty", 32'(exp_rr.size()), 32'd0);
    ch_ovf_clr = 4'b0010;
    step();
    ch_ovf_clr = '0;

    // Stream 40 words through channel 0 with downstream toggling; exercises pointer wrap.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      fifo_full = cyc[0];
      if (!ch_full_rr[0]) begin
        ch_wr = 4'b0001;
        ch_wdata[0 +: DW] = 8'(sent*3 + 7);
        expect_both(0, 8'(sent*3 + 7));
        sent++;
      end else begin
        ch_wr = '0;
      end
      step();
    end
    ch_wr = '0;
    fifo_full = 1'b0;
    n = 0;
    while (exp_rr.size() != 0 && n < 80) begin
      step();
      n++;
    end
    chk("bp_rr_empty", 32'(exp_rr.size()), 32'd0);
    chk("bp_fp_empty", 32'(exp_fp.size()), 32'd0);
    chk("bp_count", 32'(ch_count_rr[0 +: CW]), 32'd0);
    chk("bp_no_ovf", 32'(ch_ovf_rr[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
